// File: rtl/servo_pwm_gen.sv
// Three-channel hobby-servo PWM generator.
// Angles arrive as 12-bit codes with one-cycle strobes, are turned into pulse
// widths in microseconds, and take effect only at a frame boundary so that a
// pulse already on the wire is never cut short or lengthened.
module servo_pwm_gen #(
    parameter int CLK_PER_US  = 100,
    parameter int FRAME_US    = 20000,
    parameter int PW_MIN_US   = 1000,
    parameter int PW_SPAN_US  = 1000,
    parameter int SYNC_UPDATE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] angle90,
    input  logic        valid90,
    input  logic [11:0] angle210,
    input  logic        valid210,
    input  logic [11:0] angle330,
    input  logic        valid330,
    output logic        pwm90,
    output logic        pwm210,
    output logic        pwm330,
    output logic        frame_start,
    output logic        applied
);

    localparam int PS_W  = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int WID_W = $clog2(PW_MIN_US + PW_SPAN_US + 1);
    localparam int CNT_W = 15;
    localparam int CMP_W = (WID_W > CNT_W) ? WID_W : CNT_W;

    localparam logic [WID_W-1:0] W_CENTRE = WID_W'(PW_MIN_US + (PW_SPAN_US >> 1));

    // Angle code to pulse width in us; the full-width product keeps the
    // truncating shift exact for any span that fits in 32 bits.
    function automatic logic [WID_W-1:0] calc_width(input logic [11:0] a);
        logic [43:0] prod;
        prod = 44'(a) * 44'(PW_SPAN_US);
        return WID_W'(PW_MIN_US) + WID_W'(prod >> 12);
    endfunction

    logic [PS_W-1:0]  prescaler;
    logic [CNT_W-1:0] frame_cnt;
    logic             us_tick;
    logic             boundary;

    logic [2:0]       valid_in;
    logic [11:0]      angle_in [3];

    logic [2:0]       vld_p0;
    logic [11:0]      angle_p0 [3];
    logic [2:0]       pend_p1;
    logic [WID_W-1:0] pend_w_p1 [3];
    logic [2:0]       load_mask;
    logic [WID_W-1:0] active_w [3];

    logic [2:0]       pwm_q;
    logic             frame_start_q;
    logic             applied_q;

    assign valid_in    = {valid330, valid210, valid90};
    assign angle_in[0] = angle90;
    assign angle_in[1] = angle210;
    assign angle_in[2] = angle330;

    assign us_tick  = (prescaler == PS_W'(CLK_PER_US - 1));
    assign boundary = us_tick && (frame_cnt == CNT_W'(FRAME_US - 1));

    // Microsecond prescaler and frame counter; the boundary is the wrap cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler <= '0;
            frame_cnt <= '0;
        end else begin
            if (us_tick)
                prescaler <= '0;
            else
                prescaler <= prescaler + PS_W'(1);
            if (boundary)
                frame_cnt <= '0;
            else if (us_tick)
                frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    // Stage 0: capture the angle on its strobe. Stage 1: width compute into the pending slot.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (valid_in[i])
                angle_p0[i] <= angle_in[i];
            if (vld_p0[i])
                pend_w_p1[i] <= calc_width(angle_p0[i]);
        end
    end

    // Strobe pipeline and pending flags; a flag raised on the boundary edge survives the clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0  <= '0;
            pend_p1 <= '0;
        end else begin
            vld_p0  <= valid_in;
            pend_p1 <= (pend_p1 & ~load_mask) | vld_p0;
        end
    end

    // Decide which pending widths move to active at this boundary.
    always_comb begin
        load_mask = '0;
        if (boundary) begin
            if (SYNC_UPDATE != 0) begin
                if (&pend_p1)
                    load_mask = 3'b111;
            end else begin
                load_mask = pend_p1;
            end
        end
    end

    // Active widths: centre after reset, reloaded only at frame boundaries.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++)
                active_w[i] <= W_CENTRE;
        end else begin
            for (int i = 0; i < 3; i++)
                if (load_mask[i])
                    active_w[i] <= pend_w_p1[i];
        end
    end

    // Registered outputs: PWM compare lags the frame counter by one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_q         <= '0;
            frame_start_q <= 1'b0;
            applied_q     <= 1'b0;
        end else begin
            frame_start_q <= boundary;
            applied_q     <= |load_mask;
            for (int i = 0; i < 3; i++)
                pwm_q[i] <= enable && (CMP_W'(frame_cnt) < CMP_W'(active_w[i]));
        end
    end

    assign pwm90       = pwm_q[0];
    assign pwm210      = pwm_q[1];
    assign pwm330      = pwm_q[2];
    assign frame_start = frame_start_q;
    assign applied     = applied_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen: one synchronous-update and one independent-update
// instance share the same stimulus and are compared cycle by cycle against a
// timestamped event model of the pulse-width rules.
module tb_servo_pwm_gen;

    localparam int CLK   = 2;
    localparam int FUS   = 40;
    localparam int PMIN  = 10;
    localparam int PSPAN = 16;
    localparam int FC    = CLK * FUS;
    localparam int CENTRE = PMIN + (PSPAN >> 1);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] angle90 = '0, angle210 = '0, angle330 = '0;
    logic        valid90 = 1'b0, valid210 = 1'b0, valid330 = 1'b0;

    logic pwm90_s, pwm210_s, pwm330_s, fs_s, app_s;
    logic pwm90_i, pwm210_i, pwm330_i, fs_i, app_i;
    logic [9:0] obs;
    logic [9:0] exp_o;

    assign obs = {app_i, fs_i, pwm330_i, pwm210_i, pwm90_i,
                  app_s, fs_s, pwm330_s, pwm210_s, pwm90_s};

    servo_pwm_gen #(.CLK_PER_US(CLK), .FRAME_US(FUS), .PW_MIN_US(PMIN),
                    .PW_SPAN_US(PSPAN), .SYNC_UPDATE(1)) dut_sync (
        .clock(clock), .reset(reset), .enable(enable),
        .angle90(angle90), .valid90(valid90),
        .angle210(angle210), .valid210(valid210),
        .angle330(angle330), .valid330(valid330),
        .pwm90(pwm90_s), .pwm210(pwm210_s), .pwm330(pwm330_s),
        .frame_start(fs_s), .applied(app_s));

    servo_pwm_gen #(.CLK_PER_US(CLK), .FRAME_US(FUS), .PW_MIN_US(PMIN),
                    .PW_SPAN_US(PSPAN), .SYNC_UPDATE(0)) dut_ind (
        .clock(clock), .reset(reset), .enable(enable),
        .angle90(angle90), .valid90(valid90),
        .angle210(angle210), .valid210(valid210),
        .angle330(angle330), .valid330(valid330),
        .pwm90(pwm90_i), .pwm210(pwm210_i), .pwm330(pwm330_i),
        .frame_start(fs_i), .applied(app_i));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: time since reset, position in frame, and per-channel
    // strobe events that become pending two cycles after they arrive.
    typedef struct { int ready; int w; } ev_t;
    ev_t m_q [3][$];
    int  m_t, m_pos;
    int  m_act [2][3];
    int  m_pw  [2][3];
    bit  m_pf  [2][3];

    function automatic int width_of(input int a);
        return PMIN + (a * PSPAN) / 4096;
    endfunction

    task automatic tick();
        logic [4:0]  e [2];
        logic [11:0] ang [3];
        logic [2:0]  v;
        int us;
        bit bnd;
        bit ld;
        ev_t ev;
        ang[0] = angle90; ang[1] = angle210; ang[2] = angle330;
        v = {valid330, valid210, valid90};
        e[0] = '0;
        e[1] = '0;
        if (reset) begin
            m_t = 0;
            m_pos = 0;
            for (int c = 0; c < 3; c++) begin
                m_q[c].delete();
                for (int md = 0; md < 2; md++) begin
                    m_act[md][c] = CENTRE;
                    m_pf[md][c] = 1'b0;
                end
            end
        end else begin
            us = m_pos / CLK;
            bnd = (m_pos == FC - 1);
            for (int c = 0; c < 3; c++) begin
                while (m_q[c].size() > 0 && m_q[c][0].ready <= m_t) begin
                    for (int md = 0; md < 2; md++) begin
                        m_pf[md][c] = 1'b1;
                        m_pw[md][c] = m_q[c][0].w;
                    end
                    void'(m_q[c].pop_front());
                end
            end
            for (int md = 0; md < 2; md++) begin
                for (int c = 0; c < 3; c++)
                    e[md][c] = enable && (us < m_act[md][c]);
                e[md][3] = bnd;
                ld = 1'b0;
                if (bnd) begin
                    if (md == 0) begin
                        if (m_pf[0][0] && m_pf[0][1] && m_pf[0][2]) begin
                            for (int c = 0; c < 3; c++) begin
                                m_act[0][c] = m_pw[0][c];
                                m_pf[0][c] = 1'b0;
                            end
                            ld = 1'b1;
                        end
                    end else begin
                        for (int c = 0; c < 3; c++) begin
                            if (m_pf[1][c]) begin
                                m_act[1][c] = m_pw[1][c];
                                m_pf[1][c] = 1'b0;
                                ld = 1'b1;
                            end
                        end
                    end
                end
                e[md][4] = ld;
            end
            for (int c = 0; c < 3; c++) begin
                if (v[c]) begin
                    ev.ready = m_t + 2;
                    ev.w = width_of(int'(ang[c]));
                    m_q[c].push_back(ev);
                end
            end
            m_pos = (m_pos + 1) % FC;
            m_t++;
        end
        exp_o = {e[1], e[0]};
        @(posedge clock);
        #1;
        valid90 = 1'b0;
        valid210 = 1'b0;
        valid330 = 1'b0;
    endtask

    task automatic test_reset();
        int hi [6];
        int fs_at;
        reset = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (obs !== 10'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b want %b", obs, 10'b0);
            end
        end
        reset = 1'b0;
        for (int b = 0; b < 6; b++) hi[b] = 0;
        fs_at = -1;
        for (int k = 1; k <= 2 * FC; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL idle_frame cycle %0d: got %b want %b", k, obs, exp_o);
            end
            if (k <= FC) begin
                hi[0] += int'(obs[0]); hi[1] += int'(obs[1]); hi[2] += int'(obs[2]);
                hi[3] += int'(obs[5]); hi[4] += int'(obs[6]); hi[5] += int'(obs[7]);
            end
            if (fs_s && fs_at < 0) fs_at = k;
        end
        for (int b = 0; b < 6; b++) begin
            n_checks++;
            if (hi[b] !== 2 * CENTRE) begin
                n_fail++;
                $display("FAIL idle_high_cycles ch%0d: got %0d want %0d", b, hi[b], 2 * CENTRE);
            end
        end
        n_checks++;
        if (fs_at !== FC) begin
            n_fail++;
            $display("FAIL first_frame_start: got cycle %0d want %0d", fs_at, FC);
        end
    endtask

    task automatic test_sync_all();
        int hi [3];
        bit seen;
        for (int k = 0; k < FC && m_pos != FC / 2; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL sync_all_pre: got %b want %b", obs, exp_o);
            end
        end
        angle90 = 12'd0; angle210 = 12'd2048; angle330 = 12'd4095;
        valid90 = 1'b1; valid210 = 1'b1; valid330 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2 * FC && !seen; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL sync_all_wait: got %b want %b", obs, exp_o);
            end
            seen = fs_s;
        end
        n_checks++;
        if (!seen || app_s !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_all_applied: seen=%0d applied=%b want 1", seen, app_s);
        end
        for (int b = 0; b < 3; b++) hi[b] = 0;
        for (int k = 0; k < FC; k++) begin
            hi[0] += int'(pwm90_s); hi[1] += int'(pwm210_s); hi[2] += int'(pwm330_s);
            tick();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL sync_all_frame: got %b want %b", obs, exp_o);
            end
        end
        n_checks++;
        if (hi[0] !== 20 || hi[1] !== 36 || hi[2] !== 50) begin
            n_fail++;
            $display("FAIL sync_all_widths: got %0d/%0d/%0d want 20/36/50", hi[0], hi[1], hi[2]);
        end
    endtask

    task automatic test_partial();
        bit seen;
        for (int k = 0; k < FC && m_pos != FC / 2; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL partial_pre: got %b want %b", obs, exp_o);
            end
        end
        angle90 = 12'($urandom_range(0, 4095)); angle210 = 12'($urandom_range(0, 4095));
        valid90 = 1'b1; valid210 = 1'b1;
        for (int phase = 0; phase < 2; phase++) begin
            seen = 1'b0;
            for (int k = 0; k < 2 * FC && !seen; k++) begin
                tick();
                n_checks++;
                if (obs !== exp_o) begin
                    n_fail++;
                    $display("FAIL partial_wait%0d: got %b want %b", phase, obs, exp_o);
                end
                seen = fs_s;
            end
            n_checks++;
            if (!seen || app_s !== (phase == 1)) begin
                n_fail++;
                $display("FAIL partial_applied%0d: seen=%0d applied=%b want %0d", phase, seen, app_s, phase);
            end
            if (phase == 0) begin
                angle330 = 12'($urandom_range(0, 4095));
                valid330 = 1'b1;
            end
        end
        for (int k = 0; k < FC; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL partial_post: got %b want %b", obs, exp_o);
            end
        end
    endtask

    task automatic test_wrap_overwrite();
        int hi;
        for (int k = 0; k < FC && m_pos != FC - 3; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL wrap_pre: got %b want %b", obs, exp_o);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin angle90 = 12'd4095; valid90 = 1'b1; end
            if (k == 2) begin angle90 = 12'd0; valid90 = 1'b1; end
            tick();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL wrap_strobe: got %b want %b", obs, exp_o);
            end
        end
        n_checks++;
        if (fs_i !== 1'b1 || app_i !== 1'b1 || app_s !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_boundary: got fs=%b app_i=%b app_s=%b want 1/1/0", fs_i, app_i, app_s);
        end
        for (int f = 0; f < 2; f++) begin
            hi = 0;
            for (int k = 0; k < FC; k++) begin
                hi += int'(pwm90_i);
                tick();
                n_checks++;
                if (obs !== exp_o) begin
                    n_fail++;
                    $display("FAIL wrap_frame%0d: got %b want %b", f, obs, exp_o);
                end
            end
            n_checks++;
            if (hi !== ((f == 0) ? 50 : 20)) begin
                n_fail++;
                $display("FAIL wrap_width%0d: got %0d cycles want %0d", f, hi, (f == 0) ? 50 : 20);
            end
        end
    endtask

    task automatic test_reset_mid();
        int hi [3];
        int k_fs;
        angle90 = 12'($urandom_range(0, 4095)); angle210 = 12'($urandom_range(0, 4095));
        angle330 = 12'($urandom_range(0, 4095));
        valid90 = 1'b1; valid210 = 1'b1; valid330 = 1'b1;
        for (int k = 0; k < 2 * FC && (k < 3 || m_pos != 10); k++) begin
            tick();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL reset_mid_pre: got %b want %b", obs, exp_o);
            end
        end
        n_checks++;
        if (pwm90_s !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pulse: got %b want 1", pwm90_s);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (obs !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b want %b", obs, 10'b0);
        end
        k_fs = -1;
        for (int b = 0; b < 3; b++) hi[b] = 0;
        for (int k = 1; k <= 3 * FC && k_fs < 0; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL reset_mid_frame: got %b want %b", obs, exp_o);
            end
            hi[0] += int'(pwm90_s); hi[1] += int'(pwm210_s); hi[2] += int'(pwm330_s);
            if (fs_s) k_fs = k;
        end
        n_checks++;
        if (k_fs !== FC || app_s !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got fs at %0d applied=%b want %0d/0", k_fs, app_s, FC);
        end
        n_checks++;
        if (hi[0] !== 2 * CENTRE || hi[1] !== 2 * CENTRE || hi[2] !== 2 * CENTRE) begin
            n_fail++;
            $display("FAIL reset_mid_widths: got %0d/%0d/%0d want %0d", hi[0], hi[1], hi[2], 2 * CENTRE);
        end
    endtask

    task automatic test_enable();
        int n_fs;
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2 * FC && !seen; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL enable_pre: got %b want %b", obs, exp_o);
            end
            seen = fs_s;
        end
        enable = 1'b0;
        n_fs = 0;
        for (int k = 0; k < FC; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_o || (obs & 10'b00111_00111) !== 10'b0) begin
                n_fail++;
                $display("FAIL enable_off: got %b want %b", obs, exp_o);
            end
            n_fs += int'(fs_s);
        end
        n_checks++;
        if (n_fs !== 1) begin
            n_fail++;
            $display("FAIL enable_off_frames: got %0d frame_start want 1", n_fs);
        end
        enable = 1'b1;
        for (int k = 0; k < 2 * FC; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL enable_on: got %b want %b", obs, exp_o);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 9) == 0) begin valid90 = 1'b1; angle90 = 12'($urandom_range(0, 4095)); end
            if ($urandom_range(0, 9) == 0) begin valid210 = 1'b1; angle210 = 12'($urandom_range(0, 4095)); end
            if ($urandom_range(0, 9) == 0) begin valid330 = 1'b1; angle330 = ($urandom_range(0, 1) == 0) ? 12'd0 : 12'd4095; end
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            reset = ($urandom_range(0, 599) == 0);
            tick();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %b want %b", k, obs, exp_o);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sync_all();
        test_partial();
        test_wrap_overwrite();
        test_reset_mid();
        test_enable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
